// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO-busy stalls, branch/jump flushes,
// the multi-cycle mult/div busy tracker and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_md_use,
    input  logic        id_jump,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        perf_clr,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_count
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] LAT5 = 5'(MD_LAT);

    state_t      state_q, state_d;
    logic [4:0]  md_cnt_q, md_cnt_d;
    logic        done_q, done_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        load_use;
    logic        md_stall;
    logic        stall;

    // Busy is masked during reset so the stall path never sees a stale BUSY state.
    assign md_busy     = (state_q == BUSY) && !rst;
    assign md_done     = done_q;
    assign stall_count = stall_cnt_q;

    assign load_use = ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign md_stall = md_busy && id_md_use;
    assign stall    = load_use || md_stall;

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_md_start) begin
                    state_d  = BUSY;
                    md_cnt_d = LAT5;
                end
            end
            BUSY: begin
                // A new start while busy is deliberately dropped; the counter is not reloaded.
                if (md_cnt_q == 5'd1) begin
                    state_d  = IDLE;
                    md_cnt_d = 5'd0;
                    done_d   = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - 5'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 5'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = 16'd0;
        end else if (stall && !ex_branch_taken && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 5'd0;
            done_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stall/flush priority, HI/LO busy timing,
// reset abort and stall counter saturation/clear.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_md_use, id_jump;
    logic        ex_MemRead, ex_branch_taken, ex_md_start, perf_clr;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic        md_busy, md_done;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.MD_LAT(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_md_use(id_md_use), .id_jump(id_jump),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .perf_clr(perf_clr),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctl = {pc_write, ifid_write, ifid_flush, idex_flush}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp});
    endtask

    task automatic clear_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_md_use = 1'b0; id_jump = 1'b0;
        ex_MemRead = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0; perf_clr = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step();
        #1;
        chk_ctl("rst_ctl", 4'b0011);
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        chk("rst_cnt", stall_count, 0);

        rst = 1'b0;
        #1;
        chk_ctl("post_rst_normal", 4'b1100);
        step();

        // load-use on rs
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        chk_ctl("load_use_rs", 4'b0001);
        step();
        chk("cnt_after_lu", stall_count, 1);
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk_ctl("lu_r0_nostall", 4'b1100);
        step();
        chk("cnt_r0", stall_count, 1);

        // rt match only counts when rt is a source
        id_rs = 5'd3; id_rt = 5'd7; ex_rt = 5'd7; id_uses_rt = 1'b0;
        #1;
        chk_ctl("rt_unused", 4'b1100);
        id_uses_rt = 1'b1;
        #1;
        chk_ctl("rt_used", 4'b0001);
        step();
        chk("cnt_rt", stall_count, 2);

        // taken branch overrides stall, no count
        ex_branch_taken = 1'b1;
        #1;
        chk_ctl("branch_over_stall", 4'b1111);
        step();
        chk("cnt_branch", stall_count, 2);
        ex_branch_taken = 1'b0;

        // jump with and without load-use
        ex_MemRead = 1'b0; id_jump = 1'b1;
        #1;
        chk_ctl("jump_alone", 4'b1110);
        ex_MemRead = 1'b1;
        #1;
        chk_ctl("jump_stall", 4'b0001);
        step();
        chk("cnt_jump_stall", stall_count, 3);

        // HI/LO busy window, start held high throughout (must not reload)
        clear_in();
        perf_clr = 1'b1;
        step();
        chk("perf_clr", stall_count, 0);
        perf_clr = 1'b0;
        id_md_use = 1'b1; ex_md_start = 1'b1;
        #1;
        chk("md_t_busy", md_busy, 0);
        chk_ctl("md_t_ctl", 4'b1100);
        step();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("md_busy_%0d", k), md_busy, 1);
            chk($sformatf("md_done_%0d", k), md_done, 0);
            chk_ctl($sformatf("md_stall_%0d", k), 4'b0001);
            step();
        end
        chk("md_end_busy", md_busy, 0);
        chk("md_end_done", md_done, 1);
        chk_ctl("md_end_ctl", 4'b1100);
        chk("md_cnt8", stall_count, 8);
        // start coincident with done is accepted
        step();
        ex_md_start = 1'b0;
        chk("md2_busy", md_busy, 1);
        chk("md2_done", md_done, 0);
        step(); step(); step();
        chk("md2_cnt", stall_count, 11);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", md_busy, 0);
        chk_ctl("rst_mid_ctl", 4'b0011);
        step();
        rst = 1'b0;
        #1;
        chk("abort_busy", md_busy, 0);
        chk("abort_cnt", stall_count, 0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("abort_done_%0d", k), md_done, 0);
            step();
        end

        // saturation and clear
        clear_in();
        ex_MemRead = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        repeat (65534) step();
        chk("sat_pre", stall_count, 16'hFFFE);
        step();
        chk("sat_hit", stall_count, 16'hFFFF);
        step(); step();
        chk("sat_hold", stall_count, 16'hFFFF);
        perf_clr = 1'b1;
        step();
        chk("clr_over_inc", stall_count, 0);
        perf_clr = 1'b0;
        step();
        chk("inc_after_clr", stall_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 8: mult/div execution latency in cycles, legal range 2..31.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-006 id_md_use  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-007 id_jump  in  1  ID instruction is j/jal/jr/jalr (resolved in ID).
REQ-008 ex_MemRead, ex_rt  in  1, 5  EX instruction is a load, and its destination register.
REQ-009 ex_branch_taken  in  1  branch in EX resolved taken.
REQ-010 ex_md_start  in  1  mult/div instruction in EX starts the HI/LO unit.
REQ-011 perf_clr  in  1  clears the stall counter.
REQ-012 pc_write, ifid_write  out  1 each  PC and IF/ID register update enables.
REQ-013 ifid_flush, idex_flush  out  1 each  bubble insert into IF/ID and ID/EX.
REQ-014 md_busy, md_done  out  1 each  HI/LO unit busy; one-cycle completion pulse.
REQ-015 stall_count  out  16  number of stall cycles.

Function
REQ-016 load_use = ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
REQ-017 md_stall = md_busy & id_md_use; stall = load_use | md_stall.
REQ-018 Priority (highest first): rst, ex_branch_taken, stall, id_jump, normal.
REQ-019 ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; any stall is ignored this cycle.
REQ-020 stall (no taken branch): pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
REQ-021 id_jump (no branch, no stall): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0.
REQ-022 Normal: pc_write=1, ifid_write=1, both flushes 0.
REQ-023 All of REQ-019..022 are combinational from inputs and registered state; no added latency.
REQ-024 FSM states IDLE, BUSY; 5-bit down-counter md_cnt.
REQ-025 IDLE & ex_md_start at edge t: md_cnt <= MD_LAT, state -> BUSY; accepted regardless of ex_branch_taken.
REQ-026 BUSY: md_cnt decrements each edge; md_busy = (state==BUSY); leave to IDLE on the edge where md_cnt is 1.
REQ-027 Hence md_busy high exactly cycles t+1..t+MD_LAT; md_done is a registered pulse high only in cycle t+MD_LAT+1.
REQ-028 ex_md_start while BUSY is ignored (counter not reloaded).
REQ-029 ex_md_start in the IDLE cycle coinciding with md_done: accepted, new BUSY period per REQ-025.
REQ-030 stall_count increments by 1 on each edge where stall=1 and ex_branch_taken=0; saturates at 0xFFFF.
REQ-031 perf_clr at an edge: stall_count <= 0, overriding a simultaneous increment.

Reset
REQ-032 rst at an edge: state IDLE, md_cnt 0, md_done 0, stall_count 0; reset mid-BUSY aborts the operation with no md_done pulse.
REQ-033 While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, md_busy=0.
REQ-034 First cycle after rst deasserts: outputs follow REQ-018..022 from inputs alone.

Verification
REQ-035 ex_MemRead=1, ex_rt=5, id_rs=5 -> pc_write=0, ifid_write=0, idex_flush=1, stall_count 0->1; repeat with ex_rt=0 -> no stall.
REQ-036 ex_md_start at cycle 10, MD_LAT=8, id_md_use=1 held -> md_busy and stall cycles 11..18, md_done only at 19, stall_count +8.
REQ-037 load_use=1 and ex_branch_taken=1 same cycle -> pc_write=1, ifid_flush=1, idex_flush=1, stall_count unchanged.
REQ-038 id_jump=1 alone -> ifid_flush=1, idex_flush=0; id_jump=1 with load_use=1 -> stall response, ifid_flush=0.
REQ-039 rst asserted at cycle 14 of REQ-036 -> md_busy 0, no md_done, stall_count 0 next cycle.
REQ-040 stall_count preloaded to 0xFFFE, three stall cycles -> 0xFFFF held; perf_clr with stall -> 0.
